// File: rtl/pipeline_sum_accumulator_pkg.sv
// Shared types and default sizing for the pipelined sum accumulator.
package pipeline_sum_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    STALL = 2'd2
  } acc_state_t;

  localparam int DEF_SIZE      = 4;
  localparam int DEF_ACC_WIDTH = 16;
  localparam int DEF_TERMS     = 8;

endpackage

// File: rtl/pipeline_sum_accumulator_counter.sv
// Per-frame operand counter; terminal flags that the next increment completes the frame.
module frame_term_counter
  import pipeline_sum_accumulator_pkg::*;
#(
  parameter int TERMS = DEF_TERMS
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam int CW = $clog2(TERMS + 1);

  logic [CW-1:0] count;

  // clear together with inc restarts the count at one (first operand of a frame)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? CW'(1) : '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == CW'(TERMS - 1));

endmodule

// File: rtl/pipeline_sum_accumulator.sv
// Accumulates TERMS operands {carry,sum} per frame and presents the total on a valid/ready output.
module pipeline_sum_accumulator
  import pipeline_sum_accumulator_pkg::*;
#(
  parameter int SIZE      = DEF_SIZE,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int TERMS     = DEF_TERMS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [SIZE-1:0]      sum,
  input  logic                 carry,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 result_overflow,
  output logic                 drop,
  output logic                 busy
);

  acc_state_t           state;
  logic [ACC_WIDTH-1:0] acc;
  logic                 acc_ovf;
  logic [ACC_WIDTH-1:0] operand;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 ovf_next;
  logic                 frame_done;
  logic                 cnt_clear;
  logic                 cnt_inc;
  logic                 terminal;
  logic                 transfer;
  logic                 out_free;

  assign operand  = ACC_WIDTH'({carry, sum});
  assign sum_wide = {1'b0, acc} + {1'b0, operand};
  assign transfer = result_valid && result_ready;
  assign out_free = !result_valid || result_ready;

  always_comb begin
    acc_next   = operand;
    ovf_next   = 1'b0;
    frame_done = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: if (load) begin
        cnt_clear  = 1'b1;
        cnt_inc    = 1'b1;
        frame_done = (TERMS == 1);
      end
      ACCUM: if (load) begin
        acc_next   = sum_wide[ACC_WIDTH-1:0];
        ovf_next   = acc_ovf | sum_wide[ACC_WIDTH];
        frame_done = terminal;
        cnt_clear  = terminal;
        cnt_inc    = !terminal;
      end
      default: ;
    endcase
  end

  frame_term_counter #(.TERMS(TERMS)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .terminal (terminal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      acc             <= '0;
      acc_ovf         <= 1'b0;
      result          <= '0;
      result_valid    <= 1'b0;
      result_overflow <= 1'b0;
    end else begin
      if (transfer) result_valid <= 1'b0;
      case (state)
        IDLE, ACCUM: if (load) begin
          acc     <= acc_next;
          acc_ovf <= ovf_next;
          if (!frame_done) begin
            state <= ACCUM;
          end else if (out_free) begin
            result          <= acc_next;
            result_overflow <= ovf_next;
            result_valid    <= 1'b1;
            state           <= IDLE;
          end else begin
            state <= STALL;
          end
        end
        STALL: if (transfer) begin
          result          <= acc;
          result_overflow <= acc_ovf;
          result_valid    <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Discard is visible in the cycle the rejected operand is presented
  assign drop = (state == STALL) && load;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pipeline_sum_accumulator.sv
// Directed bench for pipeline_sum_accumulator with SIZE=4, ACC_WIDTH=6, TERMS=4.
module tb_pipeline_sum_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] sum;
  logic       carry;
  logic [5:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       result_overflow;
  logic       drop;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  pipeline_sum_accumulator #(.SIZE(4), .ACC_WIDTH(6), .TERMS(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .load            (load),
    .sum             (sum),
    .carry           (carry),
    .result          (result),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_overflow (result_overflow),
    .drop            (drop),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic l, input logic c, input logic [3:0] s);
    load  = l;
    carry = c;
    sum   = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; load = 1'b0; sum = '0; carry = 1'b0; result_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_ovf", result_overflow, 0);
    check("rst_drop", drop, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // basic frame: 3 + 7 + 18 + 0 = 28
    result_ready = 1'b1;
    step(1, 0, 3);
    check("basic_busy", busy, 1);
    check("basic_valid_early", result_valid, 0);
    step(1, 0, 7);
    step(1, 1, 2);
    step(1, 0, 0);
    check("basic_valid", result_valid, 1);
    check("basic_result", result, 28);
    check("basic_ovf", result_overflow, 0);
    check("basic_idle", busy, 0);
    step(0, 0, 0);
    check("basic_valid_1cyc", result_valid, 0);

    // overflow: 4 * 31 = 124 -> 60 mod 64
    repeat (4) step(1, 1, 15);
    check("ovf_valid", result_valid, 1);
    check("ovf_result", result, 60);
    check("ovf_flag", result_overflow, 1);
    step(1, 0, 1);
    check("ovf_consumed", result_valid, 0);
    repeat (3) step(1, 0, 1);
    check("ovf_next_result", result, 4);
    check("ovf_next_flag", result_overflow, 0);
    check("ovf_next_valid", result_valid, 1);
    step(0, 0, 0);
    check("ovf_next_clear", result_valid, 0);

    // backpressure: A=4 held while B=8 stalls
    result_ready = 1'b0;
    repeat (4) step(1, 0, 1);
    check("bp_a_result", result, 4);
    step(1, 0, 2);
    check("bp_accum_nodrop", drop, 0);
    check("bp_a_hold", result, 4);
    repeat (3) step(1, 0, 2);
    check("bp_stall_busy", busy, 1);
    check("bp_stall_result", result, 4);
    check("bp_stall_valid", result_valid, 1);
    load = 1'b0; #1;
    check("bp_stall_noload_drop", drop, 0);
    load = 1'b1; sum = 4'd2; #1;
    check("bp_drop", drop, 1);
    @(posedge clk); #1;
    check("bp_drop_hold", result, 4);
    check("bp_drop_busy", busy, 1);
    load = 1'b0; result_ready = 1'b1; #1;
    check("bp_drop_end", drop, 0);
    @(posedge clk); #1;
    check("bp_b_result", result, 8);
    check("bp_b_valid", result_valid, 1);
    check("bp_b_idle", busy, 0);
    step(0, 0, 0);
    check("bp_b_clear", result_valid, 0);

    // last load of B coincides with transfer of A
    result_ready = 1'b0;
    repeat (4) step(1, 0, 1);
    check("sim_a_result", result, 4);
    repeat (3) step(1, 0, 2);
    result_ready = 1'b1; load = 1'b1; sum = 4'd2; #1;
    check("sim_nodrop", drop, 0);
    @(posedge clk); #1;
    check("sim_b_result", result, 8);
    check("sim_b_valid", result_valid, 1);
    check("sim_b_idle", busy, 0);
    step(0, 0, 0);
    check("sim_b_clear", result_valid, 0);

    // reset mid-frame discards the partial sum
    repeat (2) step(1, 0, 5);
    check("mrst_busy_before", busy, 1);
    load = 1'b0; #1;
    reset = 1'b1; #1;
    check("mrst_result", result, 0);
    check("mrst_valid", result_valid, 0);
    check("mrst_ovf", result_overflow, 0);
    check("mrst_drop", drop, 0);
    check("mrst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) step(1, 0, 1);
    check("mrst_partial_lost", result_valid, 0);
    repeat (2) step(1, 0, 1);
    check("mrst_result_after", result, 4);
    check("mrst_valid_after", result_valid, 1);
    step(0, 0, 0);

    // gapped input: 4 * 3 = 12
    repeat (3) begin
      step(1, 0, 3);
      step(0, 0, 0);
      step(0, 0, 0);
    end
    check("gap_busy", busy, 1);
    check("gap_valid_early", result_valid, 0);
    step(1, 0, 3);
    check("gap_result", result, 12);
    check("gap_valid", result_valid, 1);
    step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_sum_accumulator.md
PIPELINE_SUM_ACCUMULATOR -- requirements
Module: pipeline_sum_accumulator

Interface
- REQ-001 The block SHALL have parameter SIZE, default 4, meaning the width of the upstream adder sum.
- REQ-002 The block SHALL have parameter ACC_WIDTH, default 16, meaning the accumulator and result width; ACC_WIDTH >= SIZE+1.
- REQ-003 The block SHALL have parameter TERMS, default 8, meaning the number of accepted operands per frame; TERMS >= 1.
- REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
- REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous, active-high.
- REQ-006 The block SHALL have port load, input, 1 bit, operand valid (driven by the upstream adder's load_out); there is no upstream backpressure.
- REQ-007 The block SHALL have port sum, input, SIZE bits, the upstream adder sum.
- REQ-008 The block SHALL have port carry, input, 1 bit, the upstream adder carry-out.
- REQ-009 The block SHALL have port result, output, ACC_WIDTH bits, the completed frame total.
- REQ-010 The block SHALL have port result_valid, output, 1 bit, result holds an unconsumed frame.
- REQ-011 The block SHALL have port result_ready, input, 1 bit, the consumer accepts; transfer = result_valid && result_ready.
- REQ-012 The block SHALL have port result_overflow, output, 1 bit, the frame wrapped past ACC_WIDTH; qualified by result_valid.
- REQ-013 The block SHALL have port drop, output, 1 bit, a one-cycle pulse when an operand is discarded.
- REQ-014 The block SHALL have port busy, output, 1 bit, high when the state is not IDLE.

Function
- REQ-015 The operand SHALL be {carry,sum}, SIZE+1 bits, zero-extended to ACC_WIDTH.
- REQ-016 Accumulation SHALL be modulo 2^ACC_WIDTH; any carry out of bit ACC_WIDTH-1 SHALL set a per-frame sticky overflow flag.
- REQ-017 The FSM SHALL have exactly three states: IDLE, ACCUM and STALL.
- REQ-018 In IDLE with load high: acc = operand, count = 1, overflow flag = 0; the next state is ACCUM, or frame-complete handling if TERMS == 1.
- REQ-019 In ACCUM with load high: acc += operand, count += 1; load-low cycles leave acc and count unchanged.
- REQ-020 Frame complete (the accepted operand makes count == TERMS): if the output register is free, or is freed by a transfer in the same cycle, the output register SHALL load the final acc and overflow, result_valid SHALL be 1 next cycle, and the FSM SHALL go to IDLE; otherwise the FSM SHALL go to STALL holding the final acc.
- REQ-021 Latency SHALL be one cycle from the edge accepting the last operand to result_valid high.
- REQ-022 In STALL, on a transfer: the output register SHALL load the held acc and overflow, result_valid SHALL stay 1, and the FSM SHALL go to IDLE.
- REQ-023 In STALL, a load SHALL be discarded and drop SHALL pulse in the same cycle; this includes a load in the cycle of the transfer.
- REQ-024 A transfer with no pending frame SHALL clear result_valid next cycle.
- REQ-025 result and result_overflow SHALL be stable while result_valid is high and result_ready is low.
- REQ-026 drop SHALL never pulse in IDLE or ACCUM.

Reset
- REQ-027 Asserting reset, including mid-frame or in STALL, SHALL immediately set state = IDLE, acc = 0, count = 0, result = 0, result_valid = 0, result_overflow = 0, drop = 0 and busy = 0.
- REQ-028 The first load after reset deasserts SHALL start a new frame; partial frames SHALL be lost.

Structure
- REQ-029 The shared package SHALL hold the state enum acc_state_t (IDLE, ACCUM, STALL) and the default SIZE, ACC_WIDTH and TERMS constants.
- REQ-030 The term counter SHALL be a sub-module, frame_term_counter, with width $clog2(TERMS+1), clear, increment and terminal-count output.

Verification (bench: SIZE=4, ACC_WIDTH=6, TERMS=4)
- REQ-031 Basic frame: loads {0,3}, {0,7}, {1,2}, {0,0}, result_ready=1 -> result=28, overflow=0, result_valid for exactly 1 cycle, 1 cycle after the last load.
- REQ-032 Overflow: four loads of {1,15}=31 -> result=60 (124 mod 64), result_overflow=1; the next frame of four 1s -> result=4, overflow=0.
- REQ-033 Backpressure: result_ready=0; frame A of four 1s, then frame B of four 2s -> result=4 held, busy=1, state STALL; a fifth load -> drop pulse; result_ready=1 -> result=8 next cycle, then result_valid=0.
- REQ-034 Simultaneous events: result_valid=1 (value 4) and result_ready=1 in the same cycle frame B's last load is accepted -> result=8 next cycle, result_valid continuous, no drop.
- REQ-035 Reset mid-operation: two loads of 5, then a reset pulse -> all outputs 0 immediately; next four loads of 1 -> result=4.
- REQ-036 Gapped input: four loads of 3 separated by 2 idle cycles each -> result=12, same as back-to-back.
